mips_multicycle_control_unit: RTL and testbench
===============================================

Name: mips_multicycle_control_unit

Overview:
- Parametrised successor to the single-cycle MIPS control decoder: a Moore FSM driving a multicycle datapath with one shared memory.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory-ready handshake and flags illegal opcodes.
- Sits between the instruction register's opcode field and all datapath mux/enable controls.

Parameters:
OPCODE_W, 6, opcode field width
STATE_W, 4, state register width (minimum 4)
OP_RTYPE, 0, R-type opcode
OP_J, 2, jump opcode
OP_BEQ, 4, branch-equal opcode
OP_ADDI, 8, add-immediate opcode
OP_LW, 35, load-word opcode
OP_SW, 43, store-word opcode

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Opcode  in  OPCODE_W  IR[31:26]; stable from DECODE until the next FETCH
MemReady  in  1  memory completes the current read/write this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
ALUSrcB, ALUOp, PCSource  out  2 each  datapath mux selects / ALU op class
State  out  STATE_W  current state, for debug
IllegalOp  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (Reset=0, async): State=IDLE(0), IllegalOp=0, all control outputs 0. Reset mid-instruction aborts it; nothing is committed.
- All controls are a combinational decode of State (Moore). The only exceptions are PCWrite and IRWrite in FETCH, which are gated by MemReady.
- Unlisted outputs are 0 in each state.
- States and transitions:
  IDLE(0): no outputs -> FETCH unconditionally (one cycle after reset release).
  FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=MemReady. MemReady=1 -> DECODE, else hold.
  DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00. LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDI_EX. Any other opcode -> FETCH and IllegalOp set.
  MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
  MEMRD(4): MemRead=1, IorD=1. MemReady=1 -> MEMWB, else hold.
  MEMWB(5): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  MEMWR(6): MemWrite=1, IorD=1. MemReady=1 -> FETCH, else hold.
  EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RCOMP.
  RCOMP(8): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  JUMP(10): PCWrite=1, PCSource=10 -> FETCH.
  ADDI_EX(11): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
  ADDI_WB(12): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  Codes 13..(2^STATE_W-1): unreachable; if entered, outputs 0 and next state FETCH.
- Cycle counts with MemReady always 1, fetch through last state: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each extra cycle MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle; held outputs stay stable.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as MemWrite.
- IllegalOp: set on the DECODE->FETCH illegal transition; cleared only by reset.
- Opcode is sampled only in DECODE and MEMADR; values in other states are don't-care.

Optional Feature:
CU_ADDI_EN
- Defined: ADDI_EX/ADDI_WB exist and OP_ADDI decodes as above.
- Undefined: those states are not built; OP_ADDI is illegal (DECODE -> FETCH, IllegalOp set).

Test Plan:
- Reset=0 for 3 cycles, release: State=0 with all outputs 0; next cycle State=1, MemRead=1, ALUSrcB=01.
- Opcode=35, MemReady=1: states 1,2,3,4,5,1. MEMWB shows MemtoReg=1, RegWrite=1, RegDst=0.
- Opcode=43, MemReady low for 2 cycles in MEMWR: State=6 held 3 cycles with MemWrite=1, IorD=1, then 1. No RegWrite at any point.
- Opcode=0 then 4 then 2: R-type shows ALUOp=10 in EXEC and RegDst=1 in RCOMP; BEQ shows PCWriteCond=1, PCSource=01; J shows PCWrite=1, PCSource=10.
- MemReady=0 for 4 cycles in FETCH: IRWrite=PCWrite=0 throughout, State=1. MemReady=1: IRWrite=PCWrite=1 for one cycle, then State=2.
- Opcode=63: DECODE->FETCH, IllegalOp=1 and stays 1 through a following LW. Reset=0 mid-MEMRD: State=0, IllegalOp=0 immediately. Repeat with Opcode=8 with and without CU_ADDI_EN.

Source files
------------

// File: rtl/mips_multicycle_control_unit.sv
// mips_multicycle_control_unit
//   Moore FSM control unit for a multicycle MIPS datapath with one shared
//   memory. Each instruction runs through fetch, decode, execute, memory and
//   writeback states. The unit stalls on MemReady and flags illegal opcodes.
//
// Ports:
//   CLK        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   Opcode     in   IR[31:26]; sampled only in DECODE and MEMADR
//   MemReady   in   memory finishes the current read/write this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegDst, RegWrite, ALUSrcA           out  single-bit datapath controls
//   ALUSrcB, ALUOp, PCSource            out  2-bit mux selects / ALU op class
//   State      out  current state (debug)
//   IllegalOp  out  sticky illegal-opcode flag, cleared only by reset
//
// Build option:
//   CU_ADDI_EN  defined   -> ADDI_EX/ADDI_WB states exist, OP_ADDI executes
//               undefined -> OP_ADDI is treated as an illegal opcode
module mips_multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4,
  parameter int OP_RTYPE = 0,
  parameter int OP_J     = 2,
  parameter int OP_BEQ   = 4,
  parameter int OP_ADDI  = 8,
  parameter int OP_LW    = 35,
  parameter int OP_SW    = 43
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic [STATE_W-1:0]  State,
  output logic                IllegalOp
);

  localparam logic [STATE_W-1:0] ST_IDLE    = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_FETCH   = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_DECODE  = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_MEMADR  = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_MEMRD   = STATE_W'(4);
  localparam logic [STATE_W-1:0] ST_MEMWB   = STATE_W'(5);
  localparam logic [STATE_W-1:0] ST_MEMWR   = STATE_W'(6);
  localparam logic [STATE_W-1:0] ST_EXEC    = STATE_W'(7);
  localparam logic [STATE_W-1:0] ST_RCOMP   = STATE_W'(8);
  localparam logic [STATE_W-1:0] ST_BRANCH  = STATE_W'(9);
  localparam logic [STATE_W-1:0] ST_JUMP    = STATE_W'(10);
`ifdef CU_ADDI_EN
  localparam logic [STATE_W-1:0] ST_ADDI_EX = STATE_W'(11);
  localparam logic [STATE_W-1:0] ST_ADDI_WB = STATE_W'(12);
`endif

  localparam logic [OPCODE_W-1:0] C_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] C_J     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] C_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] C_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] C_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] C_SW    = OPCODE_W'(OP_SW);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               illegal;
  logic               illegal_dec;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      illegal <= illegal | illegal_dec;
    end
  end

  // Next-state logic; unknown and unreachable codes fall back to FETCH.
  always_comb begin
    state_nxt   = ST_FETCH;
    illegal_dec = 1'b0;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (Opcode == C_LW || Opcode == C_SW) begin
          state_nxt = ST_MEMADR;
        end else if (Opcode == C_RTYPE) begin
          state_nxt = ST_EXEC;
        end else if (Opcode == C_BEQ) begin
          state_nxt = ST_BRANCH;
        end else if (Opcode == C_J) begin
          state_nxt = ST_JUMP;
`ifdef CU_ADDI_EN
        end else if (Opcode == C_ADDI) begin
          state_nxt = ST_ADDI_EX;
`else
        end else if (Opcode == C_ADDI) begin
          // ADDI support not built: handled like any other unknown opcode.
          state_nxt   = ST_FETCH;
          illegal_dec = 1'b1;
`endif
        end else begin
          state_nxt   = ST_FETCH;
          illegal_dec = 1'b1;
        end
      end
      ST_MEMADR: begin
        if (Opcode == C_LW)      state_nxt = ST_MEMRD;
        else if (Opcode == C_SW) state_nxt = ST_MEMWR;
        else                     state_nxt = ST_FETCH;
      end
      ST_MEMRD:  state_nxt = MemReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_nxt = ST_FETCH;
      ST_MEMWR:  state_nxt = MemReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_nxt = ST_RCOMP;
      ST_RCOMP:  state_nxt = ST_FETCH;
      ST_BRANCH: state_nxt = ST_FETCH;
      ST_JUMP:   state_nxt = ST_FETCH;
`ifdef CU_ADDI_EN
      ST_ADDI_EX: state_nxt = ST_ADDI_WB;
      ST_ADDI_WB: state_nxt = ST_FETCH;
`endif
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // Moore output decode; only FETCH's PCWrite/IRWrite look at MemReady.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    ALUOp       = '0;
    PCSource    = '0;
    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      ST_DECODE: ALUSrcB = 2'b11;
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ST_RCOMP: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef CU_ADDI_EN
      ST_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_ADDI_WB: RegWrite = 1'b1;
`endif
      default: ;
    endcase
  end

  assign State     = state;
  assign IllegalOp = illegal;

endmodule

// File: tb/tb_mips_multicycle_control_unit.sv
// tb_mips_multicycle_control_unit
//   Scoreboard bench: each driven cycle pushes the expected state, control
//   vector and IllegalOp; a negedge monitor pops and compares.
//   Honours CU_ADDI_EN the same way as the design.
module tb_mips_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic       IllegalOp;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  mips_multicycle_control_unit #(
    .OPCODE_W(6),
    .STATE_W (4)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Opcode     (Opcode),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .State      (State),
    .IllegalOp  (IllegalOp)
  );

  always #5 CLK = ~CLK;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
  logic [15:0] obs_ctrl;
  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Expected control vectors written out from the state table.
  function automatic logic [15:0] ctrl_of(input logic [3:0] st, input logic mr);
    case (st)
      4'd1:    return {mr, 3'b001, 2'b00, mr, 3'b000, 2'b01, 2'b00, 2'b00};
      4'd2:    return 16'b0000_0000_00_11_00_00;
      4'd3:    return 16'b0000_0000_01_10_00_00;
      4'd4:    return 16'b0011_0000_00_00_00_00;
      4'd5:    return 16'b0000_0100_10_00_00_00;
      4'd6:    return 16'b0010_1000_00_00_00_00;
      4'd7:    return 16'b0000_0000_01_00_10_00;
      4'd8:    return 16'b0000_0001_10_00_00_00;
      4'd9:    return 16'b0100_0000_01_00_01_01;
      4'd10:   return 16'b1000_0000_00_00_00_10;
      4'd11:   return 16'b0000_0000_01_10_00_00;
      4'd12:   return 16'b0000_0000_10_00_00_00;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle and queue what the DUT must show during it.
  task automatic drive(input logic mr, input logic [5:0] op,
                       input logic [3:0] st, input logic ill);
    exp_t e;
    MemReady = mr;
    Opcode   = op;
    e.st   = st;
    e.ctrl = ctrl_of(st, mr);
    e.ill  = ill;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_now();
    check("rst_state", {28'd0, State}, 32'd0);
    check("rst_ctrl",  {16'd0, obs_ctrl}, 32'd0);
    check("rst_ill",   {31'd0, IllegalOp}, 32'd0);
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", {28'd0, State}, {28'd0, e.st});
      check("ctrl",  {16'd0, obs_ctrl}, {16'd0, e.ctrl});
      check("ill",   {31'd0, IllegalOp}, {31'd0, e.ill});
      check("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
      check("rw_wr_excl", {31'd0, RegWrite & MemWrite}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset    = 1'b0;
    MemReady = 1'b0;
    Opcode   = 6'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_now();
    Reset = 1'b1;

    // Idle then LW with MemReady always high: 0,1,2,3,4,5,1
    drive(1'b1, 6'd35, 4'd0, 1'b0);
    drive(1'b1, 6'd35, 4'd1, 1'b0);
    drive(1'b1, 6'd35, 4'd2, 1'b0);
    drive(1'b1, 6'd35, 4'd3, 1'b0);
    drive(1'b1, 6'd35, 4'd4, 1'b0);
    drive(1'b1, 6'd35, 4'd5, 1'b0);

    // SW with two wait cycles in MEMWR
    drive(1'b1, 6'd43, 4'd1, 1'b0);
    drive(1'b1, 6'd43, 4'd2, 1'b0);
    drive(1'b1, 6'd43, 4'd3, 1'b0);
    drive(1'b0, 6'd43, 4'd6, 1'b0);
    drive(1'b0, 6'd43, 4'd6, 1'b0);
    drive(1'b1, 6'd43, 4'd6, 1'b0);

    // R-type, BEQ, J
    drive(1'b1, 6'd0, 4'd1, 1'b0);
    drive(1'b1, 6'd0, 4'd2, 1'b0);
    drive(1'b1, 6'd0, 4'd7, 1'b0);
    drive(1'b1, 6'd0, 4'd8, 1'b0);
    drive(1'b1, 6'd4, 4'd1, 1'b0);
    drive(1'b1, 6'd4, 4'd2, 1'b0);
    drive(1'b1, 6'd4, 4'd9, 1'b0);
    drive(1'b1, 6'd2, 4'd1, 1'b0);
    drive(1'b1, 6'd2, 4'd2, 1'b0);
    drive(1'b1, 6'd2, 4'd10, 1'b0);

    // Fetch stall for 4 cycles, then J
    for (int i = 0; i < 4; i++) drive(1'b0, 6'd2, 4'd1, 1'b0);
    drive(1'b1, 6'd2, 4'd1, 1'b0);
    drive(1'b1, 6'd2, 4'd2, 1'b0);
    drive(1'b1, 6'd2, 4'd10, 1'b0);

    // Illegal opcode, then LW with the sticky flag up, reset mid-MEMRD
    drive(1'b1, 6'd63, 4'd1, 1'b0);
    drive(1'b1, 6'd63, 4'd2, 1'b0);
    drive(1'b1, 6'd35, 4'd1, 1'b1);
    drive(1'b1, 6'd35, 4'd2, 1'b1);
    drive(1'b1, 6'd35, 4'd3, 1'b1);
    drive(1'b0, 6'd35, 4'd4, 1'b1);
    drive(1'b0, 6'd35, 4'd4, 1'b1);
    Reset = 1'b0;
    #1;
    check_reset_now();
    @(posedge CLK);
    #1;
    Reset = 1'b1;

    // ADDI: executes when built in, illegal otherwise
    drive(1'b1, 6'd8, 4'd0, 1'b0);
    drive(1'b1, 6'd8, 4'd1, 1'b0);
    drive(1'b1, 6'd8, 4'd2, 1'b0);
`ifdef CU_ADDI_EN
    drive(1'b1, 6'd8, 4'd11, 1'b0);
    drive(1'b1, 6'd8, 4'd12, 1'b0);
    drive(1'b1, 6'd8, 4'd1, 1'b0);
`else
    drive(1'b1, 6'd35, 4'd1, 1'b1);
    drive(1'b1, 6'd35, 4'd2, 1'b1);
    drive(1'b1, 6'd35, 4'd3, 1'b1);
    drive(1'b0, 6'd35, 4'd4, 1'b1);
    Reset = 1'b0;
    #1;
    check_reset_now();
    Reset = 1'b1;
`endif

    @(negedge CLK);
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
